// File: rtl/csr_issue_ctrl_pkg.sv
// Shared encodings for the CSR issue stage: funct3 values, CSR-unit op codes,
// exception causes and the issue FSM state type.
package csr_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [2:0] OP_RW  = 3'd0;
  localparam logic [2:0] OP_RS  = 3'd1;
  localparam logic [2:0] OP_RC  = 3'd2;
  localparam logic [2:0] OP_RWI = 3'd3;
  localparam logic [2:0] OP_RSI = 3'd4;
  localparam logic [2:0] OP_RCI = 3'd5;

  localparam logic [3:0] CAUSE_NONE         = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSN = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_DRAIN = 3'd4
  } csr_state_e;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 != 3'b000) && (f3 != 3'b100);
  endfunction

  function automatic logic [2:0] f3_to_op(input logic [2:0] f3);
    logic [2:0] op;
    case (f3)
      F3_CSRRW:  op = OP_RW;
      F3_CSRRS:  op = OP_RS;
      F3_CSRRC:  op = OP_RC;
      F3_CSRRWI: op = OP_RWI;
      F3_CSRRSI: op = OP_RSI;
      F3_CSRRCI: op = OP_RCI;
      default:   op = OP_RW;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/csr_issue_ctrl_if.sv
// Bundle of the enqueue, CSR-unit and writeback signals of csr_issue_ctrl.
// slave = the issue stage itself, master = everything around it.
interface csr_issue_ctrl_if #(parameter int TAG_W = 6);
  // Enqueue: a transfer happens on a rising clk edge where in_valid && in_ready;
  // in_valid may not wait on in_ready, and in_* payload is sampled only then.
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic [11:0]      in_csr_addr;
  logic [63:0]      in_rs1_val;
  logic [4:0]       in_zimm;
  logic [4:0]       in_rd;
  logic [TAG_W-1:0] in_tag;
  logic [TAG_W-1:0] rob_head_tag;
  logic             flush;
  logic             csr_issue_valid;
  logic [2:0]       csr_op;
  logic [11:0]      csr_addr;
  logic [63:0]      csr_write_data;
  logic             csr_commit_ready;
  logic [63:0]      csr_read_data;
  logic             csr_illegal;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [63:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_exc;
  logic [3:0]       wb_cause;

  modport slave (
    input  in_valid, in_funct3, in_csr_addr, in_rs1_val, in_zimm, in_rd, in_tag,
           rob_head_tag, flush, csr_commit_ready, csr_read_data, csr_illegal,
    output in_ready, csr_issue_valid, csr_op, csr_addr, csr_write_data,
           wb_valid, wb_rd, wb_data, wb_tag, wb_exc, wb_cause
  );

  modport master (
    output in_valid, in_funct3, in_csr_addr, in_rs1_val, in_zimm, in_rd, in_tag,
           rob_head_tag, flush, csr_commit_ready, csr_read_data, csr_illegal,
    input  in_ready, csr_issue_valid, csr_op, csr_addr, csr_write_data,
           wb_valid, wb_rd, wb_data, wb_tag, wb_exc, wb_cause
  );
endinterface

// File: rtl/csr_issue_fifo.sv
// In-order instruction buffer for the CSR issue stage; DEPTH must be a power of
// two so the pointers wrap for free. clear empties it on the next edge.
module csr_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  // A full FIFO refuses a push even when the head is popped in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/csr_issue_ctrl.sv
// Serialising CSR issue stage: holds CSR instructions until they reach the ROB
// head, issues them one at a time, returns the old value. Option: CSR_ISSUE_TIMEOUT_EN.
module csr_issue_ctrl
  import csr_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 6,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  csr_issue_ctrl_if.slave   bus,
`ifdef CSR_ISSUE_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output csr_state_e        state_dbg
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("csr_issue_ctrl: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("csr_issue_ctrl: TIMEOUT must be >= 1");
  end

  typedef struct packed {
    logic [2:0]       funct3;
    logic [11:0]      addr;
    logic [63:0]      rs1_val;
    logic [4:0]       zimm;
    logic [4:0]       rd;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t     in_entry, head;
  logic       full, empty, push, pop, eligible;
  csr_state_e state_q, state_d;

  logic             issue_q, issue_d;
  logic [2:0]       op_q, op_d;
  logic [11:0]      addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic             wbv_q, wbv_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [63:0]      wb_data_q, wb_data_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic             wb_exc_q, wb_exc_d;
  logic [3:0]       wb_cause_q, wb_cause_d;

  assign in_entry = '{funct3: bus.in_funct3, addr: bus.in_csr_addr, rs1_val: bus.in_rs1_val,
                      zimm: bus.in_zimm, rd: bus.in_rd, tag: bus.in_tag};
  assign bus.in_ready = !full && !bus.flush;
  assign push         = bus.in_valid && bus.in_ready;

  csr_issue_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bus.flush),
    .push  (push),
    .pop   (pop),
    .din   (in_entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Only the oldest uncommitted instruction may touch CSR state.
  assign eligible = !empty && !bus.flush && (head.tag == bus.rob_head_tag);

`ifdef CSR_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit, tmo_set, timeout_err_q;

  assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT - 1));
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if ((state_d == ST_WAIT || state_d == ST_DRAIN) && state_d != state_q)
        tmo_cnt <= '0;
      else if (state_q == ST_WAIT || state_q == ST_DRAIN)
        tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_set) timeout_err_q <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    issue_d    = 1'b0;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wbv_d      = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_tag_d   = wb_tag_q;
    wb_exc_d   = wb_exc_q;
    wb_cause_d = wb_cause_q;
    pop        = 1'b0;
`ifdef CSR_ISSUE_TIMEOUT_EN
    tmo_set    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (eligible) begin
          if (f3_legal(head.funct3)) begin
            state_d = ST_ISSUE;
            issue_d = 1'b1;
            op_d    = f3_to_op(head.funct3);
            addr_d  = head.addr;
            wdata_d = head.funct3[2] ? {59'd0, head.zimm} : head.rs1_val;
          end else begin
            state_d    = ST_WB;
            wbv_d      = 1'b1;
            wb_rd_d    = head.rd;
            wb_tag_d   = head.tag;
            wb_data_d  = '0;
            wb_exc_d   = 1'b1;
            wb_cause_d = CAUSE_ILLEGAL_INSN;
          end
        end
      end
      ST_ISSUE: state_d = bus.flush ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        // The unit has already acted; a flush must still absorb its completion.
        if (bus.flush) begin
          state_d = bus.csr_commit_ready ? ST_IDLE : ST_DRAIN;
        end else if (bus.csr_commit_ready) begin
          state_d    = ST_WB;
          wbv_d      = 1'b1;
          wb_rd_d    = head.rd;
          wb_tag_d   = head.tag;
          wb_data_d  = bus.csr_illegal ? 64'd0 : bus.csr_read_data;
          wb_exc_d   = bus.csr_illegal;
          wb_cause_d = bus.csr_illegal ? CAUSE_ILLEGAL_INSN : CAUSE_NONE;
`ifdef CSR_ISSUE_TIMEOUT_EN
        end else if (tmo_hit) begin
          state_d    = ST_WB;
          wbv_d      = 1'b1;
          wb_rd_d    = head.rd;
          wb_tag_d   = head.tag;
          wb_data_d  = '0;
          wb_exc_d   = 1'b1;
          wb_cause_d = CAUSE_ILLEGAL_INSN;
          tmo_set    = 1'b1;
`endif
        end
      end
      ST_WB: begin
        pop     = 1'b1;
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (bus.csr_commit_ready) begin
          state_d = ST_IDLE;
`ifdef CSR_ISSUE_TIMEOUT_EN
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          tmo_set = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      issue_q    <= 1'b0;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wbv_q      <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_tag_q   <= '0;
      wb_exc_q   <= 1'b0;
      wb_cause_q <= '0;
    end else begin
      state_q    <= state_d;
      issue_q    <= issue_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wbv_q      <= wbv_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_tag_q   <= wb_tag_d;
      wb_exc_q   <= wb_exc_d;
      wb_cause_q <= wb_cause_d;
    end
  end

  assign bus.csr_issue_valid = issue_q;
  assign bus.csr_op          = op_q;
  assign bus.csr_addr        = addr_q;
  assign bus.csr_write_data  = wdata_q;
  assign bus.wb_valid        = wbv_q;
  assign bus.wb_rd           = wb_rd_q;
  assign bus.wb_data         = wb_data_q;
  assign bus.wb_tag          = wb_tag_q;
  assign bus.wb_exc          = wb_exc_q;
  assign bus.wb_cause        = wb_cause_q;
  assign state_dbg           = state_q;
endmodule

// File: tb/tb_csr_issue_ctrl.sv
// Directed bench for csr_issue_ctrl: cycle-exact latency checks, a writeback
// scoreboard and a one-cycle-latency CSR unit responder.
module tb_csr_issue_ctrl;
  import csr_pkg::*;

  localparam int TAG_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_issue_ctrl_if #(.TAG_W(TAG_W)) bus();
  csr_state_e state_dbg;
`ifdef CSR_ISSUE_TIMEOUT_EN
  logic timeout_err;
`endif

  csr_issue_ctrl #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
`ifdef CSR_ISSUE_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .state_dbg   (state_dbg)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_issue = 0;
  logic [70:0] exp_q[$];   // {exc, tag, data} of each expected writeback

  logic        unit_hold = 1'b0;
  logic        unit_illegal = 1'b0;
  logic [63:0] unit_rdata = '0;
  logic        pend = 1'b0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] f3, input logic [11:0] addr, input logic [63:0] rs1,
                      input logic [4:0] zimm, input logic [4:0] rd, input logic [TAG_W-1:0] tag);
    bus.in_funct3   = f3;
    bus.in_csr_addr = addr;
    bus.in_rs1_val  = rs1;
    bus.in_zimm     = zimm;
    bus.in_rd       = rd;
    bus.in_tag      = tag;
    bus.in_valid    = 1'b1;
    tick();
    bus.in_valid    = 1'b0;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!bus.csr_issue_valid && n < 12) begin
      tick();
      n++;
    end
    check("issue_wait", bus.csr_issue_valid, 1);
  endtask

  task automatic wait_wb(output int cycles);
    cycles = 0;
    while (!bus.wb_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    check("wb_wait", bus.wb_valid, 1);
  endtask

  // CSR unit model: completes one cycle after the issue pulse unless held.
  initial begin
    bus.csr_commit_ready = 1'b0;
    bus.csr_read_data    = '0;
    bus.csr_illegal      = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pend = 1'b0;
        bus.csr_commit_ready = 1'b0;
      end else begin
        if (bus.csr_commit_ready) bus.csr_commit_ready = 1'b0;
        else if (pend && !unit_hold) begin
          bus.csr_commit_ready = 1'b1;
          bus.csr_read_data    = unit_rdata;
          bus.csr_illegal      = unit_illegal;
          pend = 1'b0;
        end
        if (bus.csr_issue_valid) pend = 1'b1;
      end
    end
  end

  // Writeback scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (rst_n && bus.wb_valid) begin
        if (exp_q.size() == 0) check("wb_unexpected", 1, 0);
        else check("wb_sb", {bus.wb_exc, bus.wb_tag, bus.wb_data}, exp_q.pop_front());
      end
      if (rst_n && bus.csr_issue_valid) n_issue++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3_tab [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    logic [2:0]  op_tab [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [63:0] wd_tab [6] = '{64'h0123_4567_89ab_cdef, 64'h0123_4567_89ab_cdef,
                                64'h0123_4567_89ab_cdef, 64'd19, 64'd20, 64'd21};
    int base;
    int cyc;

    bus.in_valid = 1'b0;
    bus.in_funct3 = '0;
    bus.in_csr_addr = '0;
    bus.in_rs1_val = '0;
    bus.in_zimm = '0;
    bus.in_rd = '0;
    bus.in_tag = '0;
    bus.rob_head_tag = '0;
    bus.flush = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_issue", bus.csr_issue_valid, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_csr_op", bus.csr_op, 0);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_in_ready", bus.in_ready, 1);
`ifdef CSR_ISSUE_TIMEOUT_EN
    check("rst_timeout_err", timeout_err, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Basic CSRRW: issue at N+1, writeback at N+3
    bus.rob_head_tag = 6'd5;
    unit_rdata = 64'h1234;
    exp_q.push_back({1'b0, 6'd5, 64'h1234});
    push(3'b001, 12'h305, 64'h8000_0000, 5'd0, 5'd10, 6'd5);
    tick();
    check("rw_issue", bus.csr_issue_valid, 1);
    check("rw_op", bus.csr_op, 0);
    check("rw_addr", bus.csr_addr, 12'h305);
    check("rw_wdata", bus.csr_write_data, 64'h8000_0000);
    tick();
    check("rw_issue_once", bus.csr_issue_valid, 0);
    check("rw_no_wb_yet", bus.wb_valid, 0);
    tick();
    check("rw_wb_valid", bus.wb_valid, 1);
    check("rw_wb_data", bus.wb_data, 64'h1234);
    check("rw_wb_rd", bus.wb_rd, 10);
    check("rw_wb_exc", bus.wb_exc, 0);
    tick();
    check("rw_wb_once", bus.wb_valid, 0);
    check("rw_idle", state_dbg, ST_IDLE);

    // Immediate form waits for the ROB head
    bus.rob_head_tag = 6'd7;
    base = n_issue;
    push(3'b110, 12'h300, 64'hdead, 5'd5, 5'd3, 6'd9);
    repeat (5) tick();
    check("si_no_issue", n_issue, base);
    check("si_idle", state_dbg, ST_IDLE);
    bus.rob_head_tag = 6'd9;
    unit_rdata = 64'h77;
    exp_q.push_back({1'b0, 6'd9, 64'h77});
    tick();
    check("si_issue", bus.csr_issue_valid, 1);
    check("si_op", bus.csr_op, 4);
    check("si_wdata", bus.csr_write_data, 5);
    tick();
    tick();
    check("si_wb_data", bus.wb_data, 64'h77);
    tick();

    // Illegal funct3: writeback one cycle after eligibility, no issue
    bus.rob_head_tag = 6'd12;
    base = n_issue;
    exp_q.push_back({1'b1, 6'd12, 64'd0});
    push(3'b100, 12'h305, 64'h55, 5'd0, 5'd4, 6'd12);
    tick();
    check("ill_wb_valid", bus.wb_valid, 1);
    check("ill_exc", bus.wb_exc, 1);
    check("ill_cause", bus.wb_cause, 2);
    check("ill_rd", bus.wb_rd, 4);
    check("ill_no_issue_now", bus.csr_issue_valid, 0);
    tick();
    check("ill_no_issue", n_issue, base);

    // Privilege violation reported by the CSR unit
    bus.rob_head_tag = 6'd20;
    unit_illegal = 1'b1;
    unit_rdata = 64'habcd;
    exp_q.push_back({1'b1, 6'd20, 64'd0});
    push(3'b010, 12'h300, 64'hff, 5'd0, 5'd6, 6'd20);
    repeat (3) tick();
    check("priv_wb_valid", bus.wb_valid, 1);
    check("priv_exc", bus.wb_exc, 1);
    check("priv_cause", bus.wb_cause, 2);
    check("priv_data", bus.wb_data, 0);
    tick();
    unit_illegal = 1'b0;

    // funct3 to op / operand mapping
    for (int i = 0; i < 6; i++) begin
      bus.rob_head_tag = 6'(40 + i);
      unit_rdata = 64'(i);
      exp_q.push_back({1'b0, 6'(40 + i), 64'(i)});
      push(f3_tab[i], 12'h340, 64'h0123_4567_89ab_cdef, 5'(16 + i), 5'd1, 6'(40 + i));
      wait_issue();
      check("map_op", bus.csr_op, op_tab[i]);
      check("map_wdata", bus.csr_write_data, wd_tab[i]);
      wait_wb(cyc);
      tick();
    end

    // Full FIFO refuses a fifth push; entries drain in order
    bus.rob_head_tag = 6'd63;
    for (int t = 0; t < 4; t++) push(3'b001, 12'h300, 64'(t), 5'd0, 5'(t), 6'(t));
    check("full_ready", bus.in_ready, 0);
    push(3'b001, 12'h300, 64'd4, 5'd0, 5'd4, 6'd4);
    check("full_still", bus.in_ready, 0);
    for (int t = 0; t < 4; t++) begin
      bus.rob_head_tag = 6'(t);
      unit_rdata = 64'h100 + 64'(t);
      exp_q.push_back({1'b0, 6'(t), 64'h100 + 64'(t)});
      wait_wb(cyc);
      check("drain_tag", bus.wb_tag, t);
      tick();
    end
    bus.rob_head_tag = 6'd4;
    base = n_issue;
    repeat (4) tick();
    check("fifth_refused", n_issue, base);
    check("drain_ready", bus.in_ready, 1);

    // Flush while waiting on the CSR unit
    unit_hold = 1'b1;
    bus.rob_head_tag = 6'd30;
    push(3'b001, 12'h300, 64'd1, 5'd0, 5'd1, 6'd30);
    push(3'b001, 12'h300, 64'd2, 5'd0, 5'd2, 6'd31);
    check("fl_issue_state", state_dbg, ST_ISSUE);
    tick();
    check("fl_wait_state", state_dbg, ST_WAIT);
    bus.flush = 1'b1;
    #1;
    check("fl_ready_low", bus.in_ready, 0);
    tick();
    bus.flush = 1'b0;
    check("fl_drain_state", state_dbg, ST_DRAIN);
    unit_hold = 1'b0;
    tick();
    tick();
    check("fl_back_idle", state_dbg, ST_IDLE);
    bus.rob_head_tag = 6'd31;
    base = n_issue;
    repeat (5) tick();
    check("fl_fifo_empty", n_issue, base);
    check("fl_still_idle", state_dbg, ST_IDLE);

    // Reset in the middle of a transaction
    unit_hold = 1'b1;
    bus.rob_head_tag = 6'd50;
    push(3'b001, 12'h300, 64'd9, 5'd0, 5'd9, 6'd50);
    tick();
    tick();
    check("mr_wait_state", state_dbg, ST_WAIT);
    rst_n = 1'b0;
    #1;
    check("mr_state", state_dbg, ST_IDLE);
    check("mr_wb_valid", bus.wb_valid, 0);
    tick();
    rst_n = 1'b1;
    unit_hold = 1'b0;
    repeat (4) tick();
    check("mr_idle", state_dbg, ST_IDLE);

`ifdef CSR_ISSUE_TIMEOUT_EN
    // Withheld completion times out after 16 cycles in WAIT
    unit_hold = 1'b1;
    bus.rob_head_tag = 6'd60;
    exp_q.push_back({1'b1, 6'd60, 64'd0});
    push(3'b001, 12'h300, 64'd3, 5'd0, 5'd3, 6'd60);
    wait_issue();
    wait_wb(cyc);
    check("tmo_cycles", cyc, 17);
    check("tmo_exc", bus.wb_exc, 1);
    check("tmo_cause", bus.wb_cause, 2);
    check("tmo_err", timeout_err, 1);
    repeat (3) tick();
    check("tmo_sticky", timeout_err, 1);
    unit_hold = 1'b0;
    repeat (2) tick();
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/csr_issue_ctrl.md
# csr_issue_ctrl

Serialising issue stage placed directly upstream of the machine CSR unit. Buffers decoded SYSTEM/CSR instructions in a small in-order FIFO and holds each one until it is the ROB head, so CSR side effects are never speculative. Translates it into a single-cycle CSR-unit issue pulse and waits for the unit's completion. Returns the old CSR value, or an illegal-instruction exception, on a writeback port.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- TAG_W, 6, ROB tag width
- TIMEOUT, 16, watchdog limit in cycles (used only with CSR_ISSUE_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid / in_ready  in / out  1 / 1  enqueue handshake
- in_funct3  in  3  instruction funct3
- in_csr_addr  in  12  CSR address
- in_rs1_val  in  64  rs1 operand
- in_zimm  in  5  immediate field
- in_rd  in  5  destination register
- in_tag  in  TAG_W  ROB tag
- rob_head_tag  in  TAG_W  tag of the oldest uncommitted instruction
- flush  in  1  pipeline flush
- csr_issue_valid  out  1  one-cycle issue pulse to the CSR unit
- csr_op  out  3  0=RW, 1=RS, 2=RC, 3=RWI, 4=RSI, 5=RCI
- csr_addr  out  12  CSR address
- csr_write_data  out  64  write operand
- csr_commit_ready  in  1  CSR unit completion
- csr_read_data  in  64  old CSR value
- csr_illegal  in  1  privilege violation; valid with csr_commit_ready
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  5  destination register
- wb_data  out  64  result
- wb_tag  out  TAG_W  ROB tag
- wb_exc  out  1  exception flag
- wb_cause  out  4  cause code; 2 = illegal instruction
- timeout_err  out  1  sticky flag; present only with CSR_ISSUE_TIMEOUT_EN

## Operation
- **Enqueue:** a push occurs when in_valid and in_ready are both high. in_ready = !full && !flush.
- **Full FIFO:** no push in that cycle, even if a pop occurs in the same cycle.
- **Pointers:** read and write pointers wrap modulo DEPTH. The count tracks occupancy in the range 0..DEPTH.
- **funct3 mapping:** 001→0, 010→1, 011→2, 101→3, 110→4, 111→5. funct3 000 and 100 are illegal.
- **Write operand:** register forms drive rs1_val. Immediate forms drive zimm zero-extended to 64 bits.
- **FSM states:** IDLE, ISSUE, WAIT, WB, DRAIN.
  - IDLE→ISSUE when the FIFO is non-empty, the head tag equals rob_head_tag, and funct3 is legal.
  - IDLE→WB directly when the head funct3 is illegal, with wb_exc=1 and cause 2.
  - In ISSUE, csr_issue_valid is high for exactly one cycle; next state is WAIT.
  - WAIT→WB on csr_commit_ready, capturing csr_read_data and csr_illegal. csr_illegal maps to wb_exc=1, cause 2, wb_data=0.
  - In WB, wb_valid is high for one cycle, the head entry is popped, and next state is IDLE.
- **Flush:**
  - The FIFO empties on the next edge.
  - In IDLE or WB, the FSM goes to IDLE with no writeback.
  - In ISSUE or WAIT, the FSM goes to DRAIN, because the CSR unit has already acted.
  - DRAIN waits for csr_commit_ready, discards the result, then returns to IDLE.
  - A flush arriving while already in DRAIN is ignored.
- **Ordering:** only one instruction is in flight at a time. Strict program order is preserved.

## Timing
- **Latency:** head becomes eligible in cycle N → csr_issue_valid in N+1 → csr_commit_ready in N+2 (CSR unit latency is 1) → wb_valid in N+3.
- **Illegal funct3:** eligible in cycle N → wb_valid in N+1.
- **Throughput:** one CSR instruction every 4 cycles at best.
- **Registered outputs:** csr_* and wb_* outputs are registered and held stable in their state. wb_valid and csr_issue_valid are never high in the same cycle.
- **Reset values:** every registered output is 0, and the FSM is in IDLE with an empty FIFO. in_ready reads 1 after reset while flush is low.
- **Reset mid-operation:** an asserted reset aborts immediately; no writeback is produced.

## Configuration
- **CSR_ISSUE_TIMEOUT_EN defined:**
  - A counter clears on entry to WAIT or DRAIN and increments each cycle there.
  - On reaching TIMEOUT: in WAIT, the FSM goes to WB with wb_exc=1, cause 2, and timeout_err set. In DRAIN, it goes to IDLE and sets timeout_err.
  - timeout_err stays set until reset.
- **Not defined:** no counter and no timeout_err port. WAIT and DRAIN wait indefinitely.

## Structure
- **Package csr_pkg holds:**
  - funct3 encodings
  - csr_op codes
  - cause codes (CAUSE_ILLEGAL_INSN=2)
  - the FSM state enum
- **Sub-module csr_issue_fifo:** a parameterised DEPTH×entry FIFO exposing push, pop, head, full and empty.

## Test plan
- **Basic CSRRW:** enqueue funct3=001, addr 0x305, rs1=0x8000_0000, with the tag matching the ROB head → csr_op=0 and csr_write_data=0x8000_0000 at N+1; csr_read_data=0x1234 returned → wb_data=0x1234 at N+3.
- **Immediate form and head ordering:** enqueue CSRRSI with zimm=5, whose tag does not match the ROB head → no issue; rob_head_tag then matches → csr_op=4, write_data=5.
- **Illegal funct3:** enqueue funct3=100 → no csr_issue_valid; wb_exc=1 and wb_cause=2 one cycle after the entry becomes eligible.
- **CSR-unit privilege violation:** csr_illegal=1 with csr_commit_ready → wb_exc=1, cause 2, wb_data=0.
- **Full FIFO and ordered drain:** fill 4 entries → in_ready=0 and a fifth push is refused; all four drain in order with tags 0,1,2,3.
- **Flush in WAIT:** assert flush while in WAIT → FIFO empties, the following commit_ready is absorbed, no wb_valid is produced, and the FSM returns to IDLE.
- **Timeout (macro defined):** withhold csr_commit_ready for 16 cycles → wb_exc=1 and timeout_err=1.
